trackball_decoder: RTL and testbench
====================================

Name: trackball_decoder

Overview:
- Receiving end of the trackball interface: consumes h_clk/h_dir and v_clk/v_dir pulse streams (one toggle per count step, dir=1 = negative) and accumulates them into per-axis up/down position counters, as the game board's trackball input logic does.
- CPU-side snapshot/read port returns a Centipede-style input byte per axis.
- Sits between the trackball emulator (or a real trackball input) and the CPU input mux.

Parameters:
- COUNT_WIDTH, 4, width of each axis position counter (wraps modulo 2^COUNT_WIDTH).
- FILTER_CYCLES, 4, consecutive clk cycles a synchronized pulse level must hold before a toggle is accepted; range 1..255.
- IDLE_CYCLES, 65535, clk cycles without an accepted step before the axis active flag clears.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flip  in  1  cocktail flip; inverts the effective direction of both axes
- h_clk_in  in  1  horizontal step toggle, asynchronous to clk
- h_dir_in  in  1  horizontal direction, 1 = decrement
- v_clk_in  in  1  vertical step toggle
- v_dir_in  in  1  vertical direction, 1 = decrement
- snap  in  1  one-cycle strobe: copy both live counters and directions into the read latches
- rd_sel  in  1  0 = horizontal, 1 = vertical
- rd_data  out  8  {dir_latched, 7-COUNT_WIDTH zeros, count_latched}; for COUNT_WIDTH = 4 this is {dir, 3'b000, count[3:0]}
- h_active  out  1  horizontal step accepted within the last IDLE_CYCLES
- v_active  out  1  vertical step accepted within the last IDLE_CYCLES

Behaviour:
- Reset (asynchronous) clears every register: synchronizers, filters, counters, latches, idle timers. After reset rd_data = 0, h_active = 0, v_active = 0.
- Input path, per axis:
  - clk and dir each pass through a 2-FF synchronizer.
  - Filter holds the accepted level (reset 0) and a candidate counter. While the synchronized clk differs from the accepted level, the counter increments; any cycle it matches, the counter clears. When the counter reaches FILTER_CYCLES, the accepted level flips and a one-cycle step pulse fires.
  - Latency from an input toggle to the step pulse is 2 + FILTER_CYCLES clk cycles.
- Counting, per axis:
  - On a step pulse, effective_dir = synchronized dir XOR flip.
  - effective_dir = 0 increments the counter; effective_dir = 1 decrements it.
  - The counter wraps modulo 2^COUNT_WIDTH (15+1 -> 0, 0-1 -> 15).
  - last_dir register takes effective_dir on each step.
  - Direction is sampled in the same cycle as the step, so a dir change that is coincident with a clk toggle uses the dir value present at filter acceptance.
- Activity, per axis:
  - A step reloads the idle counter to IDLE_CYCLES and sets active = 1.
  - Otherwise the idle counter decrements; active clears in the cycle the counter reaches 0.
- Snapshot/read:
  - On snap, both axes' {last_dir, counter} are copied into the read latches.
  - rd_data is combinational from the latches and rd_sel.
  - snap coincident with a step: the latch captures the pre-step value; the live counter still updates.
  - Without snap, the latches hold indefinitely.
- Simultaneous horizontal and vertical steps are fully independent and are never lost.
- Reset mid-pulse discards any partially filtered toggle.

Decomposition:
- Shared package trackball_pkg holds:
  - DIR_POS / DIR_NEG constants
  - default COUNT_WIDTH
  - the rd_data field layout (dir bit index, count field position)
- One sub-module, trackball_axis, instantiated twice. It contains:
  - synchronizers, glitch filter, up/down counter, last_dir, idle timer
  - outputs: count, last_dir, step, active
- The top level holds flip gating, snapshot latches and the read mux.

Test Plan:
- Reset, then 5 h_clk_in toggles spaced 100 cycles apart with h_dir_in = 0, then snap, rd_sel = 0 -> rd_data = 8'h05 and h_active = 1.
- Counter at 0, then 3 v_clk_in toggles with v_dir_in = 1, then snap, rd_sel = 1 -> rd_data = 8'h8D (dir = 1, count 13); 19 further increments give count 0 after wrap.
- Glitch: h_clk_in high for 3 cycles then low, with FILTER_CYCLES = 4 -> no step, count unchanged. Hold high for 4 cycles -> exactly one step, arriving 6 cycles after the edge.
- flip = 1, 2 h toggles with h_dir_in = 0 -> count 14, dir bit 1. snap asserted in the same cycle as a step pulse -> latch shows the pre-step value; the next snap shows the post-step value.
- IDLE_CYCLES = 16: one step, then no input -> h_active drops exactly 16 cycles after the step. Assert reset mid-sequence with count 7 -> rd_data = 0 and active = 0 immediately (asynchronously).

Source files
------------

// File: rtl/trackball_pkg.sv
// ----------------------------------------------------------------------------
// trackball_pkg
// Shared definitions for the trackball receiver: direction encoding, the
// default counter width and the layout of the CPU read byte.
// ----------------------------------------------------------------------------
package trackball_pkg;

    // Direction encoding: a 1 on a dir line means the axis moves negative.
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    localparam int DEFAULT_COUNT_WIDTH = 4;

    // CPU read byte: {dir, zero padding, count}.
    localparam int RD_WIDTH     = 8;
    localparam int RD_DIR_BIT   = 7;
    localparam int RD_COUNT_LSB = 0;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_sel_t;

endpackage

// File: rtl/trackball_axis.sv
// ----------------------------------------------------------------------------
// trackball_axis
// One axis of the trackball receiver: synchronizes the asynchronous step
// toggle and direction lines, filters glitches on the toggle line, keeps the
// wrapping position counter with its last direction, and an activity timer.
//
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   invert      flips the effective direction (cocktail flip)
//   pulse       step toggle, asynchronous to clk
//   dir         direction, 1 = decrement, asynchronous to clk
//   count       live position counter
//   last_dir    effective direction of the most recent step
//   step        one-cycle pulse per accepted toggle
//   active      a step was accepted within the last IDLE_CYCLES cycles
// ----------------------------------------------------------------------------
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int FILTER_CYCLES = 4,
    parameter int IDLE_CYCLES   = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   invert,
    input  logic                   pulse,
    input  logic                   dir,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   last_dir,
    output logic                   step,
    output logic                   active
);

    localparam int                IDLE_W      = $clog2(IDLE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD   = IDLE_W'(IDLE_CYCLES);
    localparam logic [7:0]        FILTER_LAST = 8'(FILTER_CYCLES - 1);

    logic              pulse_meta;
    logic              pulse_sync;
    logic              dir_meta;
    logic              dir_sync;
    logic              level;
    logic [7:0]        filt_cnt;
    logic              accept;
    logic              step_dir;
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_meta <= 1'b0;
            pulse_sync <= 1'b0;
            dir_meta   <= 1'b0;
            dir_sync   <= 1'b0;
        end else begin
            pulse_meta <= pulse;
            pulse_sync <= pulse_meta;
            dir_meta   <= dir;
            dir_sync   <= dir_meta;
        end
    end

    // The edge whose cycle would bring the candidate count up to
    // FILTER_CYCLES is the acceptance edge itself.
    assign accept = (pulse_sync != level) && (filt_cnt == FILTER_LAST);

    // Direction is captured at acceptance so a dir change coincident with
    // the toggle uses the value present when the filter accepts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level    <= 1'b0;
            filt_cnt <= '0;
            step     <= 1'b0;
            step_dir <= DIR_POS;
        end else begin
            step <= accept;
            if (pulse_sync != level) begin
                if (accept) begin
                    level    <= ~level;
                    filt_cnt <= '0;
                    step_dir <= dir_sync ^ invert;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // The counter moves in the step cycle's following edge, so a snapshot
    // taken during the step pulse still sees the pre-step value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            last_dir <= DIR_POS;
        end else if (step) begin
            last_dir <= step_dir;
            if (step_dir == DIR_NEG) begin
                count <= count - COUNT_WIDTH'(1);
            end else begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            active   <= 1'b0;
        end else if (accept) begin
            idle_cnt <= IDLE_LOAD;
            active   <= 1'b1;
        end else if (idle_cnt != '0) begin
            idle_cnt <= idle_cnt - IDLE_W'(1);
            if (idle_cnt == IDLE_W'(1)) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trackball_decoder.sv
// ----------------------------------------------------------------------------
// trackball_decoder
// Receiving end of the trackball interface. Two axis decoders turn the
// h/v toggle streams into position counters; a snapshot strobe copies both
// into read latches that the CPU reads one axis at a time.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   flip                    cocktail flip, inverts both axis directions
//   h_clk_in, h_dir_in      horizontal step toggle and direction (1 = dec)
//   v_clk_in, v_dir_in      vertical step toggle and direction (1 = dec)
//   snap                    copy live counters and directions into latches
//   rd_sel                  0 = horizontal, 1 = vertical
//   rd_data                 {dir, zero padding, count} of the selected latch
//   h_active, v_active      axis saw a step within the last IDLE_CYCLES
// ----------------------------------------------------------------------------
module trackball_decoder
    import trackball_pkg::*;
#(
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int FILTER_CYCLES = 4,
    parameter int IDLE_CYCLES   = 65535
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flip,
    input  logic                h_clk_in,
    input  logic                h_dir_in,
    input  logic                v_clk_in,
    input  logic                v_dir_in,
    input  logic                snap,
    input  logic                rd_sel,
    output logic [RD_WIDTH-1:0] rd_data,
    output logic                h_active,
    output logic                v_active
);

    logic [COUNT_WIDTH-1:0] h_count;
    logic [COUNT_WIDTH-1:0] v_count;
    logic                   h_last_dir;
    logic                   v_last_dir;
    logic                   h_step;
    logic                   v_step;
    logic [COUNT_WIDTH-1:0] h_lat_count;
    logic [COUNT_WIDTH-1:0] v_lat_count;
    logic                   h_lat_dir;
    logic                   v_lat_dir;

    // Step pulses are not needed at this level; the axes act on them.
    logic unused_steps;
    assign unused_steps = h_step ^ v_step;

    trackball_axis #(
        .COUNT_WIDTH  (COUNT_WIDTH),
        .FILTER_CYCLES(FILTER_CYCLES),
        .IDLE_CYCLES  (IDLE_CYCLES)
    ) u_h (
        .clk     (clk),
        .reset   (reset),
        .invert  (flip),
        .pulse   (h_clk_in),
        .dir     (h_dir_in),
        .count   (h_count),
        .last_dir(h_last_dir),
        .step    (h_step),
        .active  (h_active)
    );

    trackball_axis #(
        .COUNT_WIDTH  (COUNT_WIDTH),
        .FILTER_CYCLES(FILTER_CYCLES),
        .IDLE_CYCLES  (IDLE_CYCLES)
    ) u_v (
        .clk     (clk),
        .reset   (reset),
        .invert  (flip),
        .pulse   (v_clk_in),
        .dir     (v_dir_in),
        .count   (v_count),
        .last_dir(v_last_dir),
        .step    (v_step),
        .active  (v_active)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_lat_count <= '0;
            v_lat_count <= '0;
            h_lat_dir   <= DIR_POS;
            v_lat_dir   <= DIR_POS;
        end else if (snap) begin
            h_lat_count <= h_count;
            v_lat_count <= v_count;
            h_lat_dir   <= h_last_dir;
            v_lat_dir   <= v_last_dir;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_sel == AXIS_V) begin
            rd_data[RD_DIR_BIT]                      = v_lat_dir;
            rd_data[RD_COUNT_LSB +: COUNT_WIDTH]     = v_lat_count;
        end else begin
            rd_data[RD_DIR_BIT]                      = h_lat_dir;
            rd_data[RD_COUNT_LSB +: COUNT_WIDTH]     = h_lat_count;
        end
    end

endmodule

// File: tb/tb_trackball_decoder.sv
// ----------------------------------------------------------------------------
// tb_trackball_decoder
// Self-checking bench for trackball_decoder: a directed table, hand-written
// corner sequences (glitch filter, wrap, flip, snap/step collision, idle
// timeout, asynchronous reset) and a randomized run against a step-level
// reference model.
// ----------------------------------------------------------------------------
module tb_trackball_decoder;

    localparam int CW   = 4;
    localparam int FC   = 4;
    localparam int IC   = 16;
    localparam int LAT  = FC + 2;
    localparam int MODN = 1 << CW;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flip = 1'b0;
    logic       h_clk_in = 1'b0;
    logic       h_dir_in = 1'b0;
    logic       v_clk_in = 1'b0;
    logic       v_dir_in = 1'b0;
    logic       snap = 1'b0;
    logic       rd_sel = 1'b0;
    logic [7:0] rd_data;
    logic       h_active;
    logic       v_active;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: counts as plain integers, activity from absolute
    // acceptance times.
    int         m_h_count, m_v_count;
    bit         m_h_dir, m_v_dir;
    bit         h_seen, v_seen;
    int         h_acc, v_acc;
    logic [7:0] lat_h, lat_v;

    typedef struct {
        bit         h_tog;
        bit         h_dir;
        bit         v_tog;
        bit         v_dir;
        bit         flip;
        logic [7:0] exp_h;
        logic [7:0] exp_v;
    } vec_t;

    vec_t table_v[6];

    trackball_decoder #(
        .COUNT_WIDTH  (CW),
        .FILTER_CYCLES(FC),
        .IDLE_CYCLES  (IC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .flip    (flip),
        .h_clk_in(h_clk_in),
        .h_dir_in(h_dir_in),
        .v_clk_in(v_clk_in),
        .v_dir_in(v_dir_in),
        .snap    (snap),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .h_active(h_active),
        .v_active(v_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pack_byte(input bit d, input int c);
        logic [3:0] c4;
        c4 = 4'(c);
        return {d, 3'b000, c4};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic model_clear();
        m_h_count = 0; m_v_count = 0;
        m_h_dir = 1'b0; m_v_dir = 1'b0;
        h_seen = 1'b0; v_seen = 1'b0;
        h_acc = 0; v_acc = 0;
        lat_h = 8'h00; lat_v = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        flip = 1'b0; snap = 1'b0; rd_sel = 1'b0;
        h_clk_in = 1'b0; h_dir_in = 1'b0; v_clk_in = 1'b0; v_dir_in = 1'b0;
        model_clear();
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    // Applies one set of inputs at the current negedge and advances the model.
    task automatic drive(input bit h_tog, input bit h_dir, input bit v_tog,
                         input bit v_dir, input bit f);
        bit eff;
        flip = f;
        h_dir_in = h_dir;
        v_dir_in = v_dir;
        if (h_tog) begin
            h_clk_in = ~h_clk_in;
            eff = h_dir ^ f;
            m_h_count = eff ? (m_h_count + MODN - 1) % MODN : (m_h_count + 1) % MODN;
            m_h_dir = eff;
            h_seen = 1'b1;
            h_acc = cyc + LAT;
        end
        if (v_tog) begin
            v_clk_in = ~v_clk_in;
            eff = v_dir ^ f;
            m_v_count = eff ? (m_v_count + MODN - 1) % MODN : (m_v_count + 1) % MODN;
            m_v_dir = eff;
            v_seen = 1'b1;
            v_acc = cyc + LAT;
        end
    endtask

    task automatic apply_stimulus(input bit h_tog, input bit h_dir, input bit v_tog,
                                  input bit v_dir, input bit f);
        drive(h_tog, h_dir, v_tog, v_dir, f);
        tick(10);
    endtask

    task automatic do_snap();
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        lat_h = pack_byte(m_h_dir, m_h_count);
        lat_v = pack_byte(m_v_dir, m_v_count);
    endtask

    task automatic read_axis(input bit sel, output logic [7:0] d);
        rd_sel = sel;
        #1;
        d = rd_data;
    endtask

    task automatic check_model_read(input string tag);
        logic [7:0] d;
        read_axis(1'b0, d);
        check_output({tag, "_h"}, d, lat_h);
        read_axis(1'b1, d);
        check_output({tag, "_v"}, d, lat_v);
    endtask

    task automatic check_model_active(input string tag);
        bit exp_h, exp_v;
        exp_h = h_seen && (cyc - h_acc >= 0) && (cyc - h_acc < IC);
        exp_v = v_seen && (cyc - v_acc >= 0) && (cyc - v_acc < IC);
        check_output({tag, "_hact"}, {7'b0, h_active}, {7'b0, exp_h});
        check_output({tag, "_vact"}, {7'b0, v_active}, {7'b0, exp_v});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] d;

        table_v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00};
        table_v[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80, 8'h01};
        table_v[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h8F, 8'h80};
        table_v[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h8F};
        table_v[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h8F, 8'h8F};
        table_v[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};

        // Reset state
        do_reset();
        read_axis(1'b0, d); check_output("rst_h", d, 8'h00);
        read_axis(1'b1, d); check_output("rst_v", d, 8'h00);
        check_output("rst_hact", {7'b0, h_active}, 8'h00);
        check_output("rst_vact", {7'b0, v_active}, 8'h00);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(table_v[i].h_tog, table_v[i].h_dir, table_v[i].v_tog,
                           table_v[i].v_dir, table_v[i].flip);
            do_snap();
            read_axis(1'b0, d); check_output($sformatf("tbl%0d_h", i), d, table_v[i].exp_h);
            read_axis(1'b1, d); check_output($sformatf("tbl%0d_v", i), d, table_v[i].exp_v);
        end

        // Five slow horizontal increments
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick(i == 4 ? 10 : 100);
        end
        check_output("five_hact", {7'b0, h_active}, 8'h01);
        do_snap();
        read_axis(1'b0, d); check_output("five_h", d, 8'h05);

        // Vertical decrement below zero, then wrap back to zero
        do_reset();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_snap();
        read_axis(1'b1, d); check_output("vdec_v", d, 8'h8D);
        for (int i = 0; i < 19; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_snap();
        read_axis(1'b1, d); check_output("vwrap_v", d, 8'h00);
        read_axis(1'b0, d); check_output("vwrap_h", d, 8'h00);

        // Glitch shorter than the filter is dropped
        do_reset();
        h_clk_in = 1'b1;
        tick(3);
        h_clk_in = 1'b0;
        tick(20);
        check_output("glitch_hact", {7'b0, h_active}, 8'h00);
        do_snap();
        read_axis(1'b0, d); check_output("glitch_h", d, 8'h00);

        // A level held exactly FILTER_CYCLES is accepted after 2 + FILTER_CYCLES
        h_clk_in = 1'b1;
        tick(LAT - 1);
        check_output("accept_early", {7'b0, h_active}, 8'h00);
        tick(1);
        check_output("accept_edge", {7'b0, h_active}, 8'h01);
        tick(4);
        do_snap();
        read_axis(1'b0, d); check_output("accept_h", d, 8'h01);

        // Flip inverts direction; snap during a step sees the pre-step value
        do_reset();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_snap();
        read_axis(1'b0, d); check_output("flip_h", d, 8'h8E);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(LAT);
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        read_axis(1'b0, d); check_output("snapstep_pre", d, 8'h8E);
        tick(3);
        do_snap();
        read_axis(1'b0, d); check_output("snapstep_post", d, 8'h8D);

        // Idle timeout: active drops IDLE_CYCLES after the step
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(LAT + IC - 1);
        check_output("idle_last", {7'b0, h_active}, 8'h01);
        tick(1);
        check_output("idle_drop", {7'b0, h_active}, 8'h00);

        // Asynchronous reset mid-sequence
        do_reset();
        for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_snap();
        read_axis(1'b0, d); check_output("pre_rst_h", d, 8'h07);
        check_output("pre_rst_hact", {7'b0, h_active}, 8'h01);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_rst_h", rd_data, 8'h00);
        check_output("async_rst_hact", {7'b0, h_active}, 8'h00);
        h_clk_in = 1'b0;
        model_clear();
        tick(2);
        reset = 1'b0;
        tick(20);
        check_output("post_rst_hact", {7'b0, h_active}, 8'h00);
        do_snap();
        read_axis(1'b0, d); check_output("post_rst_h", d, 8'h00);

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            tick(int'($urandom_range(8, 30)));
            check_model_active($sformatf("rnd%0d", i));
            do_snap();
            check_model_read($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
